uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_fifo_fifo.sv | 83 ++++++++
 rtl/uart_tx_fifo.sv | 98 +++++++++
 tb/tb_uart_tx_fifo.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART slice.
//   UART_HEADER_BYTE  : framing byte recognised by the header-gated echo logic
//   DEFAULT_TXQ_DEPTH : default number of entries in the transmit queue
//   txq_state_t       : states of the transmit-queue issue FSM
package uart_pkg;

  localparam logic [7:0] UART_HEADER_BYTE  = 8'hAA;
  localparam int         DEFAULT_TXQ_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } txq_state_t;

endpackage

// File: rtl/uart_tx_fifo_fifo.sv
// sync_fifo_byte: single-clock byte FIFO with sticky overflow flag.
// Ports:
//   clk_50mhz, reset_n_internal : clock, async active-low reset
//   i_wr_en, i_wr_data          : push one byte per cycle
//   i_clr_ovf                   : clear the sticky overflow flag
//   i_pop                       : pop strobe (ignored when empty)
//   o_rd_data                   : byte at the read pointer (combinational)
//   o_full, o_empty, o_count    : occupancy status
//   o_overflow                  : sticky, a push was dropped
module sync_fifo_byte
  import uart_pkg::*;
#(
  parameter  int DEPTH  = DEFAULT_TXQ_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_50mhz,
  input  logic              reset_n_internal,
  input  logic              i_wr_en,
  input  logic [7:0]        i_wr_data,
  input  logic              i_clr_ovf,
  input  logic              i_pop,
  output logic [7:0]        o_rd_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow
);

  localparam logic [ADDR_W:0] C_FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_drop;
  logic w_pop;

  assign w_full  = (r_count == C_FULL_CNT);
  assign w_empty = (r_count == '0);
  // A push against a full queue is dropped even if a pop frees a slot in
  // the same cycle: acceptance looks only at the registered count.
  assign w_push  = i_wr_en && !w_full;
  assign w_drop  = i_wr_en &&  w_full;
  assign w_pop   = i_pop   && !w_empty;

  // Storage has no reset; contents are meaningless until written.
  always_ff @(posedge clk_50mhz) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk_50mhz or negedge reset_n_internal) begin
    if (!reset_n_internal) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A new drop wins over a clear in the same cycle.
      if (w_drop)         r_overflow <= 1'b1;
      else if (i_clr_ovf) r_overflow <= 1'b0;
    end
  end

  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered transmit stage in front of the UART TX input.
// Bytes are queued in sync_fifo_byte and issued one at a time.
// Ports:
//   clk_50mhz, reset_n_internal       : clock, async active-low reset
//   i_wr_en, i_wr_data, i_clr_ovf     : producer push side / overflow clear
//   o_full, o_empty, o_count          : queue occupancy
//   o_overflow                        : sticky, a push was dropped
//   o_tx_dv, o_tx_byte                : start pulse and byte to UART TX
//   i_tx_active, i_tx_done            : UART TX busy level / finished pulse
//   o_dbg_state                       : current issue-FSM state
//
// Handshake: o_tx_dv is a one-cycle start strobe with o_tx_byte valid on
// the same cycle and held afterwards. A byte is issued only from IDLE while
// i_tx_active is low; after issuing, the FSM waits for i_tx_done (the UART's
// completion strobe) before it may issue again, so every start pulse is
// matched by exactly one done pulse. i_tx_done outside WAIT_DONE is ignored.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = DEFAULT_TXQ_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk_50mhz,
  input  logic            reset_n_internal,
  input  logic            i_wr_en,
  input  logic [7:0]      i_wr_data,
  input  logic            i_clr_ovf,
  output logic            o_full,
  output logic            o_empty,
  output logic [ADDR_W:0] o_count,
  output logic            o_overflow,
  output logic            o_tx_dv,
  output logic [7:0]      o_tx_byte,
  input  logic            i_tx_active,
  input  logic            i_tx_done,
  output logic [1:0]      o_dbg_state
);

  txq_state_t r_state;
  txq_state_t w_state_next;
  logic       w_pop;
  logic       w_empty;
  logic [7:0] w_rd_data;
  logic       r_tx_dv;
  logic [7:0] r_tx_byte;

  sync_fifo_byte #(.DEPTH(DEPTH)) u_fifo (
    .clk_50mhz        (clk_50mhz),
    .reset_n_internal (reset_n_internal),
    .i_wr_en          (i_wr_en),
    .i_wr_data        (i_wr_data),
    .i_clr_ovf        (i_clr_ovf),
    .i_pop            (w_pop),
    .o_rd_data        (w_rd_data),
    .o_full           (o_full),
    .o_empty          (w_empty),
    .o_count          (o_count),
    .o_overflow       (o_overflow)
  );

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && !i_tx_active) begin
          w_state_next = ISSUE;
          w_pop        = 1'b1;
        end
      end
      ISSUE:     w_state_next = WAIT_DONE;
      // UART busy level is not consulted here; only its done strobe counts.
      WAIT_DONE: if (i_tx_done) w_state_next = GAP;
      // One spare cycle so IDLE sees the UART's settled busy level.
      GAP:       w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz or negedge reset_n_internal) begin
    if (!reset_n_internal) begin
      r_state   <= IDLE;
      r_tx_dv   <= 1'b0;
      r_tx_byte <= 8'h00;
    end else begin
      r_state <= w_state_next;
      // The pop edge is also the issue edge, so the strobe lasts one cycle.
      r_tx_dv <= w_pop;
      if (w_pop) r_tx_byte <= w_rd_data;
    end
  end

  assign o_empty     = w_empty;
  assign o_tx_dv     = r_tx_dv;
  assign o_tx_byte   = r_tx_byte;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk_50mhz = 1'b0;
  logic       reset_n_internal;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_ovf;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       ovf;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active;
  logic       tx_done;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #10 clk_50mhz = ~clk_50mhz;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk_50mhz        (clk_50mhz),
    .reset_n_internal (reset_n_internal),
    .i_wr_en          (wr_en),
    .i_wr_data        (wr_data),
    .i_clr_ovf        (clr_ovf),
    .o_full           (full),
    .o_empty          (empty),
    .o_count          (count),
    .o_overflow       (ovf),
    .o_tx_dv          (tx_dv),
    .o_tx_byte        (tx_byte),
    .i_tx_active      (tx_active),
    .i_tx_done        (tx_done),
    .o_dbg_state      (dbg_state)
  );

  // ---------------- reference model ----------------
  // Accepted bytes in push order; the transmitted stream must equal it.
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         m_count;
  logic       m_ovf;

  always @(posedge clk_50mhz or negedge reset_n_internal) begin : model_push
    bit drop;
    if (!reset_n_internal) begin
      exp_q.delete();
      m_count = 0;
      m_ovf   = 1'b0;
    end else begin
      drop = wr_en && (m_count >= DEPTH);
      if (wr_en && m_count < DEPTH) begin
        exp_q.push_back(wr_data);
        m_count++;
      end
      if (drop)         m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  end

  // Pulse monitor: every start strobe is an issued byte; flags back-to-back
  // strobes and strobes without an intervening done.
  int dv_err = 0;
  bit dv_prev, dv_pending;
  always @(negedge clk_50mhz) begin
    if (reset_n_internal) begin
      if (tx_dv) begin
        got_q.push_back(tx_byte);
        m_count--;
        if (dv_prev || dv_pending) dv_err++;
        dv_pending = 1'b1;
      end
      dv_prev = tx_dv;
    end else begin
      dv_prev    = 1'b0;
      dv_pending = 1'b0;
    end
  end
  always @(posedge clk_50mhz) if (tx_done) dv_pending = 1'b0;

  // UART model: busy for uart_cycles after each start strobe, then done.
  bit uart_auto = 1'b0;
  int uart_cycles = 10;
  int busy_cnt = 0;
  always @(negedge clk_50mhz) begin
    if (uart_auto) begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          tx_active = 1'b0;
          tx_done   = 1'b1;
        end
      end else begin
        tx_done = 1'b0;
        if (tx_dv) begin
          tx_active = 1'b1;
          busy_cnt  = uart_cycles;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk_50mhz);
    #1;
  endtask

  task automatic apply_reset(input bit active);
    reset_n_internal = 1'b0;
    wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0;
    uart_auto = 1'b0; busy_cnt = 0;
    tx_active = active; tx_done = 1'b0;
    repeat (3) tick();
    reset_n_internal = 1'b1;
    tick();
    got_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n_internal = 1'b1;
    apply_reset(1'b0);
    n_checks++; if (tx_dv !== 1'b0) begin n_fail++; $display("FAIL reset_tx_dv: got %b expected 0", tx_dv); end
    n_checks++; if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_tx_byte: got %h expected 00", tx_byte); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", ovf); end
  endtask

  task automatic test_single_latency();
    uart_cycles = 10; uart_auto = 1'b1;
    wr_en = 1'b1; wr_data = 8'h41;
    tick();
    wr_en = 1'b0;
    n_checks++; if (count !== 5'd1 || tx_dv !== 1'b0) begin n_fail++; $display("FAIL single_count_visible: got count=%0d dv=%b expected count=1 dv=0", count, tx_dv); end
    tick();
    n_checks++; if (tx_dv !== 1'b1 || tx_byte !== 8'h41) begin n_fail++; $display("FAIL single_issue: got dv=%b byte=%h expected dv=1 byte=41", tx_dv, tx_byte); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL single_count_after_pop: got %0d expected 0", count); end
    tick();
    n_checks++; if (tx_dv !== 1'b0 || tx_byte !== 8'h41) begin n_fail++; $display("FAIL single_pulse_width: got dv=%b byte=%h expected dv=0 byte=41", tx_dv, tx_byte); end
    repeat (30) tick();
    n_checks++; if (got_q.size() !== 1 || exp_q.size() !== 1) begin n_fail++; $display("FAIL single_pulse_count: got %0d pulses expected 1", got_q.size()); end
    else if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL single_scoreboard: got %h expected %h", got_q[0], exp_q[0]); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int i;
    uart_cycles = 100; uart_auto = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wr_en = 1'b1; wr_data = 8'h30 + 8'(k);
      tick();
    end
    wr_en = 1'b0;
    for (i = 0; i < 1600 && got_q.size() < 10; i++) tick();
    repeat (120) tick();
    n_checks++; if (got_q.size() !== 10) begin n_fail++; $display("FAIL burst_pulse_count: got %0d expected 10", got_q.size()); end
    for (int k = 0; k < 10 && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== 8'h30 + 8'(k) || k >= exp_q.size() || got_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL burst_order[%0d]: got %h expected %h", k, got_q[k], 8'h30 + 8'(k));
      end
    end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL burst_overflow: got %b expected 0", ovf); end
    n_checks++; if (dv_err !== 0) begin n_fail++; $display("FAIL burst_pulse_rules: got %0d violations expected 0", dv_err); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    logic [7:0] pushed[$];
    int i;
    apply_reset(1'b1);
    for (int k = 0; k < 18; k++) begin
      wr_en = 1'b1; wr_data = 8'($urandom_range(0, 255));
      clr_ovf = (k == 17);
      pushed.push_back(wr_data);
      tick();
      if (k == 15) begin
        n_checks++; if (full !== 1'b1 || count !== 5'd16) begin n_fail++; $display("FAIL ovf_full_after_16: got full=%b count=%0d expected full=1 count=16", full, count); end
      end
    end
    wr_en = 1'b0; clr_ovf = 1'b0;
    n_checks++; if (ovf !== 1'b1 || ovf !== m_ovf) begin n_fail++; $display("FAIL ovf_set_wins: got %b expected 1", ovf); end
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_count: got %0d expected 16", count); end
    tx_active = 1'b0; uart_cycles = 20; uart_auto = 1'b1;
    for (i = 0; i < 800 && got_q.size() < 16; i++) tick();
    repeat (60) tick();
    n_checks++; if (got_q.size() !== 16) begin n_fail++; $display("FAIL ovf_drained: got %0d bytes expected 16", got_q.size()); end
    for (int k = 0; k < 16 && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== pushed[k] || got_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL ovf_order[%0d]: got %h expected %h", k, got_q[k], pushed[k]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_push_pop_full();
    int i;
    apply_reset(1'b1);
    for (int k = 0; k < 16; k++) begin
      wr_en = 1'b1; wr_data = 8'($urandom_range(0, 200));
      tick();
    end
    // Same cycle: UART goes idle (pop) and a push arrives on a full queue.
    wr_en = 1'b1; wr_data = 8'hEE; tx_active = 1'b0;
    tick();
    wr_en = 1'b0; tx_active = 1'b1;
    n_checks++; if (count !== 5'd15 || full !== 1'b0) begin n_fail++; $display("FAIL pp_count: got count=%0d full=%b expected count=15 full=0", count, full); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL pp_overflow: got %b expected 1", ovf); end
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL pp_issue: got %0d pulses expected 1", got_q.size()); end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL pp_clear: got %b expected 0", ovf); end
    tx_done = 1'b1; tx_active = 1'b0;
    tick();
    tx_done = 1'b0; uart_cycles = 5; uart_auto = 1'b1;
    for (i = 0; i < 400 && got_q.size() < 16; i++) tick();
    repeat (20) tick();
    n_checks++; if (got_q.size() !== 16 || exp_q.size() !== 16) begin n_fail++; $display("FAIL pp_drained: got %0d bytes expected 16", got_q.size()); end
    else begin
      for (int k = 0; k < 16; k++) begin
        n_checks++;
        if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL pp_order[%0d]: got %h expected %h", k, got_q[k], exp_q[k]); end
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_busy_hold();
    logic [7:0] b;
    int i;
    apply_reset(1'b1);
    b = 8'($urandom_range(0, 255));
    wr_en = 1'b1; wr_data = b;
    tick();
    wr_en = 1'b0;
    repeat (25) tick();
    n_checks++; if (got_q.size() !== 0 || count !== 5'd1) begin n_fail++; $display("FAIL busy_no_issue: got pulses=%0d count=%0d expected pulses=0 count=1", got_q.size(), count); end
    tx_active = 1'b0; uart_cycles = 10; uart_auto = 1'b1;
    for (i = 0; i < 20 && got_q.size() < 1; i++) tick();
    repeat (40) tick();
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL busy_single_pulse: got %0d expected 1", got_q.size()); end
    else begin
      n_checks++; if (got_q[0] !== b) begin n_fail++; $display("FAIL busy_byte: got %h expected %h", got_q[0], b); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int i;
    apply_reset(1'b0);
    uart_cycles = 50; uart_auto = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wr_en = 1'b1; wr_data = 8'($urandom_range(0, 255));
      tick();
    end
    wr_en = 1'b0;
    for (i = 0; i < 20 && got_q.size() < 1; i++) tick();
    tick();
    n_checks++; if (count !== 5'd5 || m_count !== 5) begin n_fail++; $display("FAIL mid_queued: got %0d expected 5", count); end
    reset_n_internal = 1'b0;
    #1;
    n_checks++; if (count !== 5'd0 || tx_dv !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL mid_reset_immediate: got count=%0d dv=%b empty=%b expected 0 0 1", count, tx_dv, empty); end
    uart_auto = 1'b0; busy_cnt = 0; tx_active = 1'b0; tx_done = 1'b0;
    repeat (2) tick();
    reset_n_internal = 1'b1;
    got_q.delete();
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    repeat (10) tick();
    n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL mid_stale_done: got %0d pulses expected 0", got_q.size()); end
    uart_cycles = 10; uart_auto = 1'b1;
    wr_en = 1'b1; wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    for (i = 0; i < 30 && got_q.size() < 1; i++) tick();
    repeat (20) tick();
    n_checks++; if (got_q.size() !== 1 || exp_q.size() !== 1) begin n_fail++; $display("FAIL mid_fresh_count: got %0d pulses expected 1", got_q.size()); end
    else if (got_q[0] !== 8'h55 || got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL mid_fresh_byte: got %h expected 55", got_q[0]); end
    n_checks++; if (dv_err !== 0) begin n_fail++; $display("FAIL pulse_rules: got %0d violations expected 0", dv_err); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_latency();
    test_back_to_back();
    test_overflow();
    test_push_pop_full();
    test_busy_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
